// File: rtl/imem_dmem_port_arbiter.sv
// Arbiter sharing one single-port fixed-latency memory between instruction fetch and the
// load/store stage. Accesses are serialised, one in flight; DM has priority with an IF starvation guard.
module imem_dmem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              grant_dm,
    output logic [1:0]        fsm_state
);

    // Handshake: a requester raises req with its address/data stable and holds it until the
    // single-cycle ack; requests are only sampled in IDLE, so a new access presented during ACK
    // is arbitrated in the following cycle.

    localparam int WCW = $clog2(MEM_LATENCY + 1);
    localparam int SCW = $clog2(STARVE_LIMIT + 1);
    localparam logic [WCW-1:0] WAIT_INIT  = WCW'(MEM_LATENCY);
    localparam logic [WCW-1:0] WAIT_LAST  = WCW'(1);
    localparam logic [SCW-1:0] STARVE_MAX = SCW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        ACK   = 2'd3
    } state_t;

    state_t         state;
    logic [WCW-1:0] wait_cnt;
    logic [SCW-1:0] starve_cnt;
    logic           is_store;
    logic           dm_win;

    assign fsm_state = state;

    // IF is forced once DM has won STARVE_LIMIT times in a row against a waiting fetch.
    assign dm_win = dm_req && !(if_req && (starve_cnt == STARVE_MAX));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            wait_cnt   <= '0;
            starve_cnt <= '0;
            is_store   <= 1'b0;
            if_rdata   <= '0;
            if_ack     <= 1'b0;
            dm_rdata   <= '0;
            dm_ack     <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            grant_dm   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_req || dm_req) begin
                        if (dm_win) begin
                            grant_dm  <= 1'b1;
                            is_store  <= dm_we;
                            mem_we    <= dm_we;
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                            if (!if_req)
                                starve_cnt <= '0;
                            else if (starve_cnt != STARVE_MAX)
                                starve_cnt <= starve_cnt + SCW'(1);
                        end else begin
                            grant_dm   <= 1'b0;
                            is_store   <= 1'b0;
                            mem_we     <= 1'b0;
                            mem_addr   <= if_addr;
                            mem_wdata  <= '0;
                            starve_cnt <= '0;
                        end
                        mem_en <= 1'b1;
                        busy   <= 1'b1;
                        state  <= ISSUE;
                    end
                end
                ISSUE: begin
                    mem_en   <= 1'b0;
                    mem_we   <= 1'b0;
                    wait_cnt <= WAIT_INIT;
                    state    <= WAIT;
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        if (!grant_dm)
                            if_rdata <= mem_rdata;
                        else if (!is_store)
                            dm_rdata <= mem_rdata;
                        if_ack   <= !grant_dm;
                        dm_ack   <= grant_dm;
                        wait_cnt <= '0;
                        state    <= ACK;
                    end else begin
                        wait_cnt <= wait_cnt - WCW'(1);
                    end
                end
                ACK: begin
                    if_ack <= 1'b0;
                    dm_ack <= 1'b0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_dmem_port_arbiter.sv
// Directed bench for imem_dmem_port_arbiter: a MEM_LATENCY=2 instance for most scenarios and a
// MEM_LATENCY=1 instance for back-to-back fetches, each fed by a behavioural fixed-latency memory.
module tb_imem_dmem_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    // Instance A: MEM_LATENCY=2
    logic        a_if_req, a_if_ack, a_dm_req, a_dm_we, a_dm_ack;
    logic [31:0] a_if_addr, a_if_rdata, a_dm_addr, a_dm_wdata, a_dm_rdata;
    logic        a_mem_en, a_mem_we, a_busy, a_grant_dm;
    logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;
    logic [1:0]  a_fsm_state;

    // Instance B: MEM_LATENCY=1
    logic        b_if_req, b_if_ack, b_dm_req, b_dm_we, b_dm_ack;
    logic [31:0] b_if_addr, b_if_rdata, b_dm_addr, b_dm_wdata, b_dm_rdata;
    logic        b_mem_en, b_mem_we, b_busy, b_grant_dm;
    logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;
    logic [1:0]  b_fsm_state;

    imem_dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(2), .STARVE_LIMIT(4)) dut_a (
        .clk(clk), .reset(rst),
        .if_req(a_if_req), .if_addr(a_if_addr), .if_rdata(a_if_rdata), .if_ack(a_if_ack),
        .dm_req(a_dm_req), .dm_we(a_dm_we), .dm_addr(a_dm_addr), .dm_wdata(a_dm_wdata),
        .dm_rdata(a_dm_rdata), .dm_ack(a_dm_ack),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .mem_rdata(a_mem_rdata), .busy(a_busy), .grant_dm(a_grant_dm), .fsm_state(a_fsm_state)
    );

    imem_dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) dut_b (
        .clk(clk), .reset(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_rdata(b_if_rdata), .if_ack(b_if_ack),
        .dm_req(b_dm_req), .dm_we(b_dm_we), .dm_addr(b_dm_addr), .dm_wdata(b_dm_wdata),
        .dm_rdata(b_dm_rdata), .dm_ack(b_dm_ack),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .mem_rdata(b_mem_rdata), .busy(b_busy), .grant_dm(b_grant_dm), .fsm_state(b_fsm_state)
    );

    // Shared memory contents; read data is present only in the single cycle it is due.
    logic [31:0] mem [logic [31:0]];
    logic [31:0] a_pipe0, a_pipe1, b_pipe0;

    function automatic logic [31:0] rd(input logic [31:0] addr);
        return mem.exists(addr) ? mem[addr] : (32'hBAD0_0000 ^ addr);
    endfunction

    always @(posedge clk) begin
        a_pipe1 <= a_pipe0;
        a_pipe0 <= (a_mem_en && !a_mem_we) ? rd(a_mem_addr) : 32'h0;
        b_pipe0 <= (b_mem_en && !b_mem_we) ? rd(b_mem_addr) : 32'h0;
        if (a_mem_en && a_mem_we) mem[a_mem_addr] = a_mem_wdata;
    end

    assign a_mem_rdata = a_pipe1;
    assign b_mem_rdata = b_pipe0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        checks++; if ({a_if_ack, a_dm_ack, a_mem_en, a_mem_we, a_busy, a_grant_dm, a_fsm_state} !== 8'h0) begin errors++; $display("FAIL reset_ctrl_a: got %h want 00", {a_if_ack, a_dm_ack, a_mem_en, a_mem_we, a_busy, a_grant_dm, a_fsm_state}); end
        checks++; if ({a_if_rdata, a_dm_rdata, a_mem_addr, a_mem_wdata} !== 128'h0) begin errors++; $display("FAIL reset_data_a: got %h want 0", {a_if_rdata, a_dm_rdata, a_mem_addr, a_mem_wdata}); end
        checks++; if ({b_if_ack, b_dm_ack, b_mem_en, b_busy, b_fsm_state, b_if_rdata} !== 38'h0) begin errors++; $display("FAIL reset_b: got %h want 0", {b_if_ack, b_dm_ack, b_mem_en, b_busy, b_fsm_state, b_if_rdata}); end
    endtask

    task automatic test_lone_fetch();
        a_if_req = 1'b1; a_if_addr = 32'h10;
        step();
        checks++; if ({a_mem_en, a_mem_we, a_busy, a_grant_dm} !== 4'b1010) begin errors++; $display("FAIL fetch_issue: got %b want 1010", {a_mem_en, a_mem_we, a_busy, a_grant_dm}); end
        checks++; if (a_mem_addr !== 32'h10) begin errors++; $display("FAIL fetch_addr: got %h want 00000010", a_mem_addr); end
        step();
        checks++; if (a_mem_en !== 1'b0) begin errors++; $display("FAIL fetch_en_pulse: got %b want 0", a_mem_en); end
        step();
        checks++; if (a_if_ack !== 1'b0) begin errors++; $display("FAIL fetch_early_ack: got %b want 0", a_if_ack); end
        step();
        checks++; if ({a_if_ack, a_dm_ack} !== 2'b10) begin errors++; $display("FAIL fetch_ack: got %b want 10", {a_if_ack, a_dm_ack}); end
        checks++; if (a_if_rdata !== 32'h00500093) begin errors++; $display("FAIL fetch_data: got %h want 00500093", a_if_rdata); end
        a_if_req = 1'b0;
        step();
        checks++; if ({a_if_ack, a_busy} !== 2'b00) begin errors++; $display("FAIL fetch_done: got %b want 00", {a_if_ack, a_busy}); end
    endtask

    task automatic test_dm_priority();
        a_if_req = 1'b1; a_if_addr = 32'h20;
        a_dm_req = 1'b1; a_dm_we = 1'b0; a_dm_addr = 32'h200;
        step();
        checks++; if ({a_mem_en, a_grant_dm, a_mem_addr} !== {2'b11, 32'h200}) begin errors++; $display("FAIL prio_grant: got %b %h want 11 00000200", {a_mem_en, a_grant_dm}, a_mem_addr); end
        step(); step(); step();
        checks++; if ({a_dm_ack, a_if_ack} !== 2'b10) begin errors++; $display("FAIL prio_dm_ack: got %b want 10", {a_dm_ack, a_if_ack}); end
        checks++; if (a_dm_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL prio_dm_data: got %h want cafef00d", a_dm_rdata); end
        a_dm_req = 1'b0;
        step();
        checks++; if ({a_mem_en, a_busy} !== 2'b00) begin errors++; $display("FAIL prio_idle5: got %b want 00", {a_mem_en, a_busy}); end
        step();
        checks++; if ({a_mem_en, a_grant_dm, a_mem_addr} !== {2'b10, 32'h20}) begin errors++; $display("FAIL prio_if_issue6: got %b %h want 10 00000020", {a_mem_en, a_grant_dm}, a_mem_addr); end
        step(); step();
        checks++; if (a_if_ack !== 1'b0) begin errors++; $display("FAIL prio_if_early: got %b want 0", a_if_ack); end
        step();
        checks++; if ({a_if_ack, a_if_rdata} !== {1'b1, 32'h11111111}) begin errors++; $display("FAIL prio_if_ack9: got %b %h want 1 11111111", a_if_ack, a_if_rdata); end
        a_if_req = 1'b0;
        step();
    endtask

    task automatic test_store();
        a_dm_req = 1'b1; a_dm_we = 1'b1; a_dm_addr = 32'h100; a_dm_wdata = 32'hDEADBEEF;
        step();
        checks++; if ({a_mem_en, a_mem_we, a_mem_addr, a_mem_wdata} !== {2'b11, 32'h100, 32'hDEADBEEF}) begin errors++; $display("FAIL store_issue: got %b %h %h want 11 00000100 deadbeef", {a_mem_en, a_mem_we}, a_mem_addr, a_mem_wdata); end
        step();
        checks++; if ({a_mem_en, a_mem_we} !== 2'b00) begin errors++; $display("FAIL store_we_pulse: got %b want 00", {a_mem_en, a_mem_we}); end
        step(); step();
        checks++; if ({a_dm_ack, a_if_ack} !== 2'b10) begin errors++; $display("FAIL store_ack: got %b want 10", {a_dm_ack, a_if_ack}); end
        checks++; if (a_dm_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL store_rdata_kept: got %h want cafef00d", a_dm_rdata); end
        a_dm_req = 1'b0; a_dm_we = 1'b0;
        step();
        checks++; if (mem[32'h100] !== 32'hDEADBEEF) begin errors++; $display("FAIL store_written: got %h want deadbeef", mem[32'h100]); end
    endtask

    task automatic test_starvation();
        logic exp_g [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic got_g [10];
        int ng = 0;
        int na = 0;
        int both_hi = 0;
        a_if_req = 1'b1; a_if_addr = 32'h20;
        a_dm_req = 1'b1; a_dm_we = 1'b0; a_dm_addr = 32'h200;
        for (int k = 0; k < 120 && na < 10; k++) begin
            step();
            if (a_mem_en && ng < 10) begin got_g[ng] = a_grant_dm; ng++; end
            if (a_if_ack && a_dm_ack) both_hi++;
            if (a_if_ack || a_dm_ack) na++;
        end
        a_if_req = 1'b0; a_dm_req = 1'b0;
        checks++; if (na != 10 || ng != 10) begin errors++; $display("FAIL starve_timeout: got acks %0d grants %0d want 10 10", na, ng); end
        for (int i = 0; i < ng; i++) begin
            checks++; if (got_g[i] !== exp_g[i]) begin errors++; $display("FAIL starve_grant%0d: got %b want %b", i, got_g[i], exp_g[i]); end
        end
        checks++; if (both_hi != 0) begin errors++; $display("FAIL starve_dual_ack: got %0d want 0", both_hi); end
        step();
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL starve_drain: got %b want 0", a_busy); end
    endtask

    task automatic test_reset_in_flight();
        a_if_req = 1'b1; a_if_addr = 32'h10;
        step(); step();
        rst = 1'b1;
        #1;
        checks++; if ({a_if_ack, a_dm_ack, a_mem_en, a_mem_we, a_busy, a_grant_dm, a_fsm_state} !== 8'h0) begin errors++; $display("FAIL midreset_ctrl: got %h want 00", {a_if_ack, a_dm_ack, a_mem_en, a_mem_we, a_busy, a_grant_dm, a_fsm_state}); end
        checks++; if ({a_if_rdata, a_dm_rdata, a_mem_addr, a_mem_wdata} !== 128'h0) begin errors++; $display("FAIL midreset_data: got %h want 0", {a_if_rdata, a_dm_rdata, a_mem_addr, a_mem_wdata}); end
        a_if_req = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (a_if_ack !== 1'b0) begin errors++; $display("FAIL midreset_noack%0d: got %b want 0", k, a_if_ack); end
        end
        rst = 1'b0;
        step();
        a_if_req = 1'b1; a_if_addr = 32'h10;
        for (int k = 1; k <= 4; k++) begin
            step();
            checks++; if (a_if_ack !== (k == 4)) begin errors++; $display("FAIL postreset_ack_c%0d: got %b want %b", k, a_if_ack, (k == 4)); end
        end
        checks++; if (a_if_rdata !== 32'h00500093) begin errors++; $display("FAIL postreset_data: got %h want 00500093", a_if_rdata); end
        a_if_req = 1'b0;
        step();
    endtask

    task automatic test_back_to_back();
        b_if_req = 1'b1; b_if_addr = 32'h0;
        for (int k = 1; k <= 8; k++) begin
            step();
            checks++; if (b_if_ack !== (k == 3 || k == 7)) begin errors++; $display("FAIL b2b_ack_c%0d: got %b want %b", k, b_if_ack, (k == 3 || k == 7)); end
            if (k == 3) begin
                checks++; if (b_if_rdata !== 32'h00000013) begin errors++; $display("FAIL b2b_data0: got %h want 00000013", b_if_rdata); end
                b_if_addr = 32'h4;
            end
            if (k == 7) begin
                checks++; if (b_if_rdata !== 32'h00100093) begin errors++; $display("FAIL b2b_data1: got %h want 00100093", b_if_rdata); end
                b_if_req = 1'b0;
            end
        end
        checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got %b want 0", b_busy); end
    endtask

    initial begin
        rst = 1'b1;
        a_if_req = 1'b0; a_if_addr = '0; a_dm_req = 1'b0; a_dm_we = 1'b0; a_dm_addr = '0; a_dm_wdata = '0;
        b_if_req = 1'b0; b_if_addr = '0; b_dm_req = 1'b0; b_dm_we = 1'b0; b_dm_addr = '0; b_dm_wdata = '0;
        mem[32'h10]  = 32'h00500093;
        mem[32'h20]  = 32'h11111111;
        mem[32'h200] = 32'hCAFEF00D;
        mem[32'h0]   = 32'h00000013;
        mem[32'h4]   = 32'h00100093;
        step(); step();
        test_reset();
        rst = 1'b0;
        step();
        test_lone_fetch();
        test_dm_priority();
        test_store();
        test_starvation();
        test_reset_in_flight();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
